// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single line-wide adaptor port between the
// read-only I-cache and the read/write D-cache. One whole line transaction
// is granted at a time. The adaptor request lines are registered. The
// adaptor response is routed back to the owning cache with no added latency.
// A watchdog flag and a D-cache read/write conflict flag are kept sticky
// until reset.
module cache_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int LINE_W         = 256,
    parameter int PRIO_MODE      = 0,     // 0: D-cache always wins, 1: round-robin
    parameter int TIMEOUT_CYCLES = 1024   // 0 disables the watchdog
) (
    input  logic              clk,
    input  logic              reset,
    // I-cache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    // D-cache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    // adaptor side
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp,
    // status
    output logic              busy,
    output logic              err_timeout,
    output logic              err_rw
);

    // The watchdog counter must be able to hold TIMEOUT_CYCLES itself.
    localparam int              WD_W     = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    // registered state
    state_t            r_state;
    logic              r_m_read;
    logic              r_m_write;
    logic [ADDR_W-1:0] r_m_address;
    logic [LINE_W-1:0] r_m_wdata;
    logic              r_rr_favour_i;   // 0: D-cache favoured on a tie, 1: I-cache
    logic [WD_W-1:0]   r_wd_count;
    logic              r_err_timeout;
    logic              r_err_rw;

    // next-state values
    state_t            w_state_next;
    logic              w_m_read_next;
    logic              w_m_write_next;
    logic [ADDR_W-1:0] w_m_address_next;
    logic [LINE_W-1:0] w_m_wdata_next;
    logic              w_rr_favour_i_next;
    logic [WD_W-1:0]   w_wd_count_next;
    logic              w_err_timeout_next;
    logic              w_err_rw_next;

    // arbitration
    logic              w_d_req;
    logic              w_pick_d;

    assign w_d_req = d_read | d_write;

    // Tie-break policy is fixed at elaboration time.
    generate
        if (PRIO_MODE == 0) begin : g_fixed_prio
            assign w_pick_d = w_d_req;
        end else begin : g_round_robin
            assign w_pick_d = w_d_req & (~i_read | ~r_rr_favour_i);
        end
    endgenerate

    // State register and all registered outputs; reset abandons any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_m_read      <= 1'b0;
            r_m_write     <= 1'b0;
            r_m_address   <= '0;
            r_m_wdata     <= '0;
            r_rr_favour_i <= 1'b0;
            r_wd_count    <= '0;
            r_err_timeout <= 1'b0;
            r_err_rw      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_m_read      <= w_m_read_next;
            r_m_write     <= w_m_write_next;
            r_m_address   <= w_m_address_next;
            r_m_wdata     <= w_m_wdata_next;
            r_rr_favour_i <= w_rr_favour_i_next;
            r_wd_count    <= w_wd_count_next;
            r_err_timeout <= w_err_timeout_next;
            r_err_rw      <= w_err_rw_next;
        end
    end

    // Next-state logic: grant in IDLE, hold until m_resp, one recovery cycle.
    always_comb begin
        w_state_next       = r_state;
        w_m_read_next      = r_m_read;
        w_m_write_next     = r_m_write;
        w_m_address_next   = r_m_address;
        w_m_wdata_next     = r_m_wdata;
        w_rr_favour_i_next = r_rr_favour_i;
        w_wd_count_next    = r_wd_count;
        w_err_timeout_next = r_err_timeout;
        w_err_rw_next      = r_err_rw;

        case (r_state)
            IDLE: begin
                if (w_pick_d) begin
                    w_state_next     = SERVE_D;
                    w_m_address_next = d_address;
                    w_wd_count_next  = '0;
                    if (d_write) begin
                        // a simultaneous read is dropped: the writeback wins
                        w_m_write_next = 1'b1;
                        w_m_wdata_next = d_wdata;
                        if (d_read) begin
                            w_err_rw_next = 1'b1;
                        end
                    end else begin
                        w_m_read_next = 1'b1;
                    end
                end else if (i_read) begin
                    w_state_next     = SERVE_I;
                    w_m_address_next = i_address;
                    w_m_read_next    = 1'b1;
                    w_wd_count_next  = '0;
                end
            end

            SERVE_I, SERVE_D: begin
                // The flag rises on the edge that completes the
                // TIMEOUT_CYCLES-th serve cycle; the FSM keeps waiting.
                if (TIMEOUT_CYCLES != 0) begin
                    if (r_wd_count != WD_LIMIT) begin
                        w_wd_count_next = r_wd_count + 1'b1;
                        if (w_wd_count_next == WD_LIMIT) begin
                            w_err_timeout_next = 1'b1;
                        end
                    end
                end
                if (m_resp) begin
                    w_state_next       = RECOVER;
                    w_m_read_next      = 1'b0;
                    w_m_write_next     = 1'b0;
                    w_rr_favour_i_next = (r_state == SERVE_D);
                end
            end

            RECOVER: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Response routing is purely combinational.
    assign i_rdata     = m_rdata;
    assign d_rdata     = m_rdata;
    assign i_resp      = m_resp & (r_state == SERVE_I);
    assign d_resp      = m_resp & (r_state == SERVE_D);

    assign m_read      = r_m_read;
    assign m_write     = r_m_write;
    assign m_address   = r_m_address;
    assign m_wdata     = r_m_wdata;
    assign busy        = (r_state != IDLE);
    assign err_timeout = r_err_timeout;
    assign err_rw      = r_err_rw;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed bench with strobe/response scoreboards.
// Instance a: fixed priority, 8-cycle watchdog. Instance b: round-robin, no watchdog.
module tb_cache_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [31:0]  i_address, d_address;
    logic [255:0] d_wdata, m_rdata;

    logic         a_i_read, a_d_read, a_d_write, a_m_resp;
    logic [255:0] a_i_rdata, a_d_rdata, a_m_wdata;
    logic [31:0]  a_m_address;
    logic         a_i_resp, a_d_resp, a_m_read, a_m_write, a_busy, a_err_timeout, a_err_rw;

    logic         b_i_read, b_d_read, b_d_write, b_m_resp;
    logic [255:0] b_i_rdata, b_d_rdata, b_m_wdata;
    logic [31:0]  b_m_address;
    logic         b_i_resp, b_d_resp, b_m_read, b_m_write, b_busy, b_err_timeout, b_err_rw;

    cache_arbiter #(.ADDR_W(32), .LINE_W(256), .PRIO_MODE(0), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .reset(reset),
        .i_read(a_i_read), .i_address(i_address), .i_rdata(a_i_rdata), .i_resp(a_i_resp),
        .d_read(a_d_read), .d_write(a_d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(a_d_rdata), .d_resp(a_d_resp),
        .m_read(a_m_read), .m_write(a_m_write), .m_address(a_m_address), .m_wdata(a_m_wdata),
        .m_rdata(m_rdata), .m_resp(a_m_resp),
        .busy(a_busy), .err_timeout(a_err_timeout), .err_rw(a_err_rw)
    );

    cache_arbiter #(.ADDR_W(32), .LINE_W(256), .PRIO_MODE(1), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset),
        .i_read(b_i_read), .i_address(i_address), .i_rdata(b_i_rdata), .i_resp(b_i_resp),
        .d_read(b_d_read), .d_write(b_d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(b_d_rdata), .d_resp(b_d_resp),
        .m_read(b_m_read), .m_write(b_m_write), .m_address(b_m_address), .m_wdata(b_m_wdata),
        .m_rdata(m_rdata), .m_resp(b_m_resp),
        .busy(b_busy), .err_timeout(b_err_timeout), .err_rw(b_err_rw)
    );

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wd;
    } strobe_t;

    typedef struct {
        logic         is_d;
        logic [255:0] data;
    } resp_t;

    strobe_t sb_q[$];
    resp_t   resp_q[$];
    int      n_cmp = 0;
    int      n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_line(output logic [255:0] v);
        for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
    endtask

    // One transaction on instance a: request in cycle 0, m_resp in cycle lat.
    task automatic txn_a(input bit is_d, input bit wr, input bit both, input logic [31:0] addr,
                         input logic [255:0] wd, input int lat, input string tag);
        strobe_t s;
        resp_t   r;
        if (is_d) begin
            d_address = addr;
            d_wdata   = wd;
            a_d_write = wr;
            a_d_read  = !wr || both;
        end else begin
            i_address = addr;
            a_i_read  = 1'b1;
        end
        s.rd = !wr; s.wr = wr; s.addr = addr; s.wd = wd;
        sb_q.push_back(s);
        tick();
        for (int k = 1; k < lat; k++) begin
            chk({tag, "_hold_rw"}, {a_m_read, a_m_write}, {!wr, wr});
            chk({tag, "_hold_addr"}, a_m_address, addr);
            if (wr) chk({tag, "_hold_wdata"}, a_m_wdata, wd);
            chk({tag, "_hold_busy"}, a_busy, 1'b1);
            tick();
        end
        rand_line(r.data);
        r.is_d   = is_d;
        m_rdata  = r.data;
        a_m_resp = 1'b1;
        resp_q.push_back(r);
        #1;
        chk({tag, "_i_resp"}, a_i_resp, !is_d);
        chk({tag, "_d_resp"}, a_d_resp, is_d);
        tick();
        a_m_resp  = 1'b0;
        a_i_read  = is_d ? a_i_read : 1'b0;
        a_d_read  = is_d ? 1'b0 : a_d_read;
        a_d_write = is_d ? 1'b0 : a_d_write;
        chk({tag, "_recover_rw"}, {a_m_read, a_m_write}, 2'b00);
        chk({tag, "_recover_busy"}, a_busy, 1'b1);
        tick();
        chk({tag, "_idle_busy"}, a_busy, 1'b0);
    endtask

    // Scoreboard monitor for instance a: strobe rising edges and response pulses.
    logic a_prev_strobe = 1'b0;
    always @(negedge clk) begin
        strobe_t s;
        resp_t   r;
        if (reset) begin
            a_prev_strobe <= 1'b0;
        end else begin
            if ((a_m_read || a_m_write) && !a_prev_strobe) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL sb_unexpected_strobe observed addr=%0h expected none", a_m_address);
                end else begin
                    s = sb_q.pop_front();
                    chk("sb_m_read", a_m_read, s.rd);
                    chk("sb_m_write", a_m_write, s.wr);
                    chk("sb_m_address", a_m_address, s.addr);
                    if (s.wr) chk("sb_m_wdata", a_m_wdata, s.wd);
                end
            end
            a_prev_strobe <= a_m_read || a_m_write;
            if (a_i_resp || a_d_resp) begin
                if (resp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL sb_unexpected_resp observed i=%0b d=%0b expected none", a_i_resp, a_d_resp);
                end else begin
                    r = resp_q.pop_front();
                    chk("sb_resp_owner", {a_i_resp, a_d_resp}, {!r.is_d, r.is_d});
                    chk("sb_rdata", r.is_d ? a_d_rdata : a_i_rdata, r.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [255:0] v;
        logic [31:0]  rr_q[$];
        logic [31:0]  exp_addr;
        int           w;

        reset = 1'b1;
        i_address = '0; d_address = '0; d_wdata = '0; m_rdata = '0;
        a_i_read = 0; a_d_read = 0; a_d_write = 0; a_m_resp = 0;
        b_i_read = 0; b_d_read = 0; b_d_write = 0; b_m_resp = 0;
        tick();
        tick();
        chk("rst_m_rw", {a_m_read, a_m_write}, 2'b00);
        chk("rst_m_address", a_m_address, 32'h0);
        chk("rst_m_wdata", a_m_wdata, 256'h0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_err", {a_err_timeout, a_err_rw}, 2'b00);
        chk("rst_resp", {a_i_resp, a_d_resp}, 2'b00);
        reset = 1'b0;
        tick();

        // 1: I-cache read, response in cycle 6
        txn_a(1'b0, 1'b0, 1'b0, 32'h0000_1000, 256'h0, 6, "t1");

        // 2: D-cache writeback
        txn_a(1'b1, 1'b1, 1'b0, 32'h0000_2040, {32{8'hA5}}, 5, "t2");
        chk("t2_err_rw_clear", a_err_rw, 1'b0);

        // 3: simultaneous reads, fixed priority -> D first, I strobe 3 cycles after d_resp
        begin
            strobe_t s;
            resp_t   r;
            i_address = 32'h0000_3000;
            d_address = 32'h0000_4000;
            a_i_read = 1'b1;
            a_d_read = 1'b1;
            s.rd = 1; s.wr = 0; s.addr = 32'h0000_4000; s.wd = '0; sb_q.push_back(s);
            s.addr = 32'h0000_3000; sb_q.push_back(s);
            tick();
            chk("t3_first_addr", a_m_address, 32'h0000_4000);
            tick();
            tick();
            rand_line(r.data); r.is_d = 1; m_rdata = r.data; resp_q.push_back(r);
            a_m_resp = 1'b1;
            #1;
            chk("t3_d_resp", {a_i_resp, a_d_resp}, 2'b01);
            tick();
            a_m_resp = 1'b0;
            a_d_read = 1'b0;
            chk("t3_gap_k1", a_m_read, 1'b0);
            tick();
            chk("t3_gap_k2", a_m_read, 1'b0);
            tick();
            chk("t3_i_strobe_k3", a_m_read, 1'b1);
            chk("t3_i_addr", a_m_address, 32'h0000_3000);
            tick();
            rand_line(r.data); r.is_d = 0; m_rdata = r.data; resp_q.push_back(r);
            a_m_resp = 1'b1;
            #1;
            chk("t3_i_resp", {a_i_resp, a_d_resp}, 2'b10);
            tick();
            a_m_resp = 1'b0;
            a_i_read = 1'b0;
            tick();
            tick();
        end

        // D-cache read and write together: served as a write, err_rw set
        txn_a(1'b1, 1'b1, 1'b1, 32'h0000_9000, {32{8'h5A}}, 2, "rw");
        chk("rw_err_rw_set", a_err_rw, 1'b1);

        // 4: round-robin with both requesting continuously -> D, I, D, I
        i_address = 32'h0000_7000;
        d_address = 32'h0000_8000;
        rr_q = '{32'h0000_8000, 32'h0000_7000, 32'h0000_8000, 32'h0000_7000};
        b_i_read = 1'b1;
        b_d_read = 1'b1;
        for (int t = 0; t < 4; t++) begin
            w = 0;
            while (!b_m_read && w < 10) begin
                tick();
                w++;
            end
            chk("t4_strobe_seen", b_m_read, 1'b1);
            exp_addr = rr_q.pop_front();
            chk("t4_grant_addr", b_m_address, exp_addr);
            tick();
            rand_line(v);
            m_rdata = v;
            b_m_resp = 1'b1;
            #1;
            chk("t4_resp_owner", {b_i_resp, b_d_resp}, {exp_addr == 32'h0000_7000, exp_addr == 32'h0000_8000});
            chk("t4_rdata", (exp_addr == 32'h0000_8000) ? b_d_rdata : b_i_rdata, v);
            tick();
            b_m_resp = 1'b0;
        end
        b_i_read = 1'b0;
        b_d_read = 1'b0;
        tick();
        tick();
        chk("t4_idle", b_busy, 1'b0);
        chk("t4_no_timeout", b_err_timeout, 1'b0);

        // 5: watchdog, no response ever
        begin
            strobe_t s;
            d_address = 32'h0000_5000;
            a_d_read = 1'b1;
            s.rd = 1; s.wr = 0; s.addr = 32'h0000_5000; s.wd = '0; sb_q.push_back(s);
            tick();
            for (int c = 1; c <= 8; c++) begin
                chk("t5_err_early", a_err_timeout, 1'b0);
                tick();
            end
            for (int c = 9; c <= 12; c++) begin
                chk("t5_err_timeout", a_err_timeout, 1'b1);
                chk("t5_busy", a_busy, 1'b1);
                chk("t5_m_read_held", a_m_read, 1'b1);
                tick();
            end
        end

        // 6: asynchronous reset mid-SERVE_D, then a pending I-cache read
        i_address = 32'h0000_6000;
        a_i_read = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_m_rw", {a_m_read, a_m_write}, 2'b00);
        chk("t6_m_address", a_m_address, 32'h0);
        chk("t6_m_wdata", a_m_wdata, 256'h0);
        chk("t6_busy", a_busy, 1'b0);
        chk("t6_err", {a_err_timeout, a_err_rw}, 2'b00);
        a_d_read = 1'b0;
        tick();
        reset = 1'b0;
        txn_a(1'b0, 1'b0, 1'b0, 32'h0000_6000, 256'h0, 4, "t6");

        tick();
        chk("sb_strobe_drained", sb_q.size(), 0);
        chk("sb_resp_drained", resp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
